dram_block_master: RTL
======================

// Module: dram_block_master
// PURPOSE
//  Initiator for the strobed-subblock DRAM port (addr/en/we/dinDstrobe/din/doutDstrobe/dout/dready/accR/accW).
//  Sits between the L2 miss/writeback path and the DRAM model or controller.
//  Converts one full-block read or write request into a subblock burst and returns one full-block response.
//  Handles one request at a time; the DRAM side is never left with a half-finished burst.
// PARAMETERS
//  ADDR_BITS   32   byte address width (matches DADDR_bits)
//  BLOCK_BITS  256  L2 block width (matches DL2block)
//  SUBBLOCKS   4    subblocks per block, power of 2 (matches DL2subblocks); SUB_W=BLOCK_BITS/SUBBLOCKS
//  SUB_LOG2    2    log2(SUBBLOCKS)
//  TIMEOUT     64   max idle cycles waiting for read data before error
// PORTS
//  clk          in   1           clock
//  reset        in   1           synchronous, active-low reset
//  req_valid    in   1           block request valid
//  req_ready    out  1           high only in IDLE
//  req_we       in   1           1=write block, 0=read block
//  req_addr     in   ADDR_BITS   byte address; low log2(BLOCK_BITS/8) bits ignored
//  req_wdata    in   BLOCK_BITS  write data; subblock k = bits [SUB_W*(k+1)-1 -: SUB_W]
//  resp_valid   out  1           response valid, held until resp_ready
//  resp_ready   in   1           response accept
//  resp_we      out  1           echo of the accepted req_we
//  resp_err     out  1           read timed out; resp_rdata undefined-but-zeroed
//  resp_rdata   out  BLOCK_BITS  assembled read block (0 for writes)
//  addrD        out  ADDR_BITS   block-aligned address, stable from accept until RESP exit
//  enD          out  1           read issue pulse
//  weD          out  1           write subblock strobe
//  dinDstrobe   out  SUB_LOG2    index of subblock on dinD
//  dinD         out  SUB_W       write subblock data
//  doutDstrobe  in   SUB_LOG2    index of subblock on doutD
//  doutD        in   SUB_W       read subblock data
//  dreadyD      in   1           doutD/doutDstrobe valid
//  accR         in   1           DRAM accepts a read issue
//  accW         in   1           DRAM write pipe drained
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; enD, weD, dinDstrobe, dinD, addrD, resp_* and buffers all 0.
//    Applies mid-burst; DRAM beats arriving later are ignored.
//  All DRAM-side outputs are registered.
//  States: IDLE, RD_ISSUE, RD_WAIT, WR_BURST, WR_DRAIN, RESP.
//  IDLE:
//    On req_valid: latch addr (aligned), we, wdata; clear rx mask and timeout counter.
//    Next state is RD_ISSUE if we=0, else WR_BURST.
//    dreadyD is ignored in IDLE.
//  RD_ISSUE:
//    Wait until accR==1 && accW==1, then drive enD=1 for exactly one cycle -> RD_WAIT.
//  RD_WAIT:
//    Each cycle with dreadyD: rdata[doutDstrobe] <= doutD and set mask bit.
//    Out-of-order strobes are accepted; a repeated strobe overwrites.
//    All SUBBLOCKS mask bits set -> RESP (earliest: cycle after final beat).
//    The counter resets on each beat; TIMEOUT cycles with no beat -> RESP with resp_err=1, rdata=0.
//  WR_BURST:
//    Wait until accW==1 && accR==1, then drive weD=1 on SUBBLOCKS consecutive cycles.
//    Beat k carries dinDstrobe=k and dinD=subblock k. No gaps; no enD during the burst. -> WR_DRAIN.
//  WR_DRAIN:
//    weD=0. The first cycle ignores accW; afterwards wait for accW==1 -> RESP.
//    Guarantees the write is committed before the response is issued.
//  RESP:
//    resp_valid=1, resp_we, resp_err, resp_rdata stable.
//    On resp_ready -> IDLE (req_ready goes high next cycle). No new request is taken in the same cycle.
//  Widths: strobe counter is SUB_LOG2 bits and wraps at SUBBLOCKS-1 -> 0 only at burst end.
//  resp_rdata is cleared on write requests.
//  Throughput: read = issue + DRAM latency + SUBBLOCKS beats + 1; write = SUBBLOCKS + drain + 1.
// TESTING
//  T1 read:
//    Mem model (ReadLatency 5), req addr 0x8040 read.
//    -> one enD pulse, addrD=0x8040 held, 4 beats assembled in order.
//    -> resp_valid with the exact 256-bit block, resp_err=0.
//  T2 write then read:
//    Write 0x8020 data 0x0123..CDEF pattern.
//    -> weD high 4 consecutive cycles, strobes 0,1,2,3, resp only after accW==1.
//    -> readback returns the identical block.
//  T3 out-of-order and duplicate beats:
//    Stub drives strobes 2,0,3,0,1.
//    -> resp after strobe 1 arrives; slot 0 holds the second strobe-0 value.
//  T4 backpressure:
//    accR=0 for 20 cycles -> no enD until accR=1.
//    resp_ready=0 for 10 cycles -> resp held stable, req_ready=0.
//  T5 timeout:
//    Stub never asserts dreadyD -> resp_err=1 exactly TIMEOUT cycles after enD. Next request works.
//  T6 reset mid-burst:
//    reset=0 during write beat 2 -> weD=0 next cycle, state IDLE.
//    Stale dreadyD after reset is ignored. Fresh read succeeds.

Source files
------------

// File: rtl/dram_block_master.sv
// Block-level initiator for a strobed-subblock DRAM port: one full-block read or
// write request becomes one subblock burst and one full-block response.
module dram_block_master #(
    parameter int ADDR_BITS  = 32,
    parameter int BLOCK_BITS = 256,
    parameter int SUBBLOCKS  = 4,
    parameter int SUB_LOG2   = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_BITS-1:0]             req_addr,
    input  logic [BLOCK_BITS-1:0]            req_wdata,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic                             resp_we,
    output logic                             resp_err,
    output logic [BLOCK_BITS-1:0]            resp_rdata,
    output logic [ADDR_BITS-1:0]             addrD,
    output logic                             enD,
    output logic                             weD,
    output logic [SUB_LOG2-1:0]              dinDstrobe,
    output logic [BLOCK_BITS/SUBBLOCKS-1:0]  dinD,
    input  logic [SUB_LOG2-1:0]              doutDstrobe,
    input  logic [BLOCK_BITS/SUBBLOCKS-1:0]  doutD,
    input  logic                             dreadyD,
    input  logic                             accR,
    input  logic                             accW,
    output logic [2:0]                       state_dbg
);
    localparam int SUB_W = BLOCK_BITS / SUBBLOCKS;
    localparam int OFF   = $clog2(BLOCK_BITS / 8);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Handshakes: a request transfers on a cycle with req_valid && req_ready;
    // a response transfers on a cycle with resp_valid && resp_ready, and
    // resp_valid with its payload holds until then.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        WR_DRAIN = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t                  state;
    logic [BLOCK_BITS-1:0]   wbuf;
    logic [SUBBLOCKS-1:0]    rx_mask;
    logic [SUBBLOCKS-1:0]    beat_bit;
    logic [SUBBLOCKS-1:0]    mask_next;
    logic [CNT_W-1:0]        to_cnt;
    logic                    drain_first;
    logic [SUB_LOG2-1:0]     nxt_strobe;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^req_addr[OFF-1:0];
    assign req_ready        = (state == IDLE);
    assign state_dbg        = state;

    always_comb begin
        beat_bit              = '0;
        beat_bit[doutDstrobe] = 1'b1;
        mask_next             = rx_mask | beat_bit;
        nxt_strobe            = dinDstrobe + {{(SUB_LOG2-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            addrD       <= '0;
            enD         <= 1'b0;
            weD         <= 1'b0;
            dinDstrobe  <= '0;
            dinD        <= '0;
            resp_valid  <= 1'b0;
            resp_we     <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            wbuf        <= '0;
            rx_mask     <= '0;
            to_cnt      <= '0;
            drain_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addrD      <= {req_addr[ADDR_BITS-1:OFF], {OFF{1'b0}}};
                        resp_we    <= req_we;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        wbuf       <= req_we ? req_wdata : '0;
                        rx_mask    <= '0;
                        to_cnt     <= '0;
                        state      <= req_we ? WR_BURST : RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (accR && accW) begin
                        enD   <= 1'b1;
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    enD <= 1'b0;
                    if (dreadyD) begin
                        resp_rdata[doutDstrobe*SUB_W +: SUB_W] <= doutD;
                        rx_mask <= mask_next;
                        to_cnt  <= '0;
                        if (&mask_next) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Partial data is discarded so an errored block reads as zero.
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                WR_BURST: begin
                    if (weD) begin
                        if (dinDstrobe == SUB_LOG2'(SUBBLOCKS - 1)) begin
                            weD         <= 1'b0;
                            dinDstrobe  <= '0;
                            dinD        <= '0;
                            drain_first <= 1'b1;
                            state       <= WR_DRAIN;
                        end else begin
                            dinDstrobe <= nxt_strobe;
                            dinD       <= wbuf[nxt_strobe*SUB_W +: SUB_W];
                        end
                    end else if (accW && accR) begin
                        weD        <= 1'b1;
                        dinDstrobe <= '0;
                        dinD       <= wbuf[SUB_W-1:0];
                    end
                end
                WR_DRAIN: begin
                    // accW may still show the pre-burst level on the first cycle.
                    if (drain_first) begin
                        drain_first <= 1'b0;
                    end else if (accW) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
